// File: rtl/mem_access_seq_if.sv
// Bundle between the CPU control path, the load/store sequencer and Memoria.
// The slave modport is the sequencer's view; the master modport is the environment's (CPU + memory).
interface mem_access_seq_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, op, addr, wdata, mem_rdata,
    output busy, done, rdata, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req, op, addr, wdata, mem_rdata,
    input  busy, done, rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer in front of Memoria: fixed read latency,
// read-modify-write for sub-word stores, sign/zero extension for sub-word loads.
module mem_access_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [2:0]  lat_cnt_reg;
  logic [15:0] wdata_lo_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        lat_last;
  logic        sub_store;

  assign lat_last  = (lat_cnt_reg == LAT_LAST);
  assign sub_store = (op_reg == OP_SH) || (op_reg == OP_SB);

  // Sub-word loads always take the low-order lanes of the returned word.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] w);
    case (op)
      OP_LH:   load_ext = {{16{w[15]}}, w[15:0]};
      OP_LHU:  load_ext = {16'h0000, w[15:0]};
      OP_LB:   load_ext = {{24{w[7]}}, w[7:0]};
      OP_LBU:  load_ext = {24'h000000, w[7:0]};
      default: load_ext = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req) state_next = (bus.op == OP_SW) ? WR : RD_WAIT;
      RD_WAIT: if (lat_last) state_next = sub_store ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_reg != IDLE);
    bus.done   = (state_reg == DONE);
    bus.mem_wr = (state_reg == WR);
  end

  assign bus.rdata     = rdata_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Request fields are latched at acceptance so later input changes cannot disturb the operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= OP_LW;
      lat_cnt_reg   <= '0;
      wdata_lo_reg  <= '0;
      rdata_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            op_reg       <= bus.op;
            wdata_lo_reg <= bus.wdata[15:0];
            mem_addr_reg <= bus.addr;
            lat_cnt_reg  <= '0;
            if (bus.op == OP_SW) mem_wdata_reg <= bus.wdata;
          end
        end
        RD_WAIT: begin
          if (lat_last) begin
            lat_cnt_reg <= '0;
            if (op_reg == OP_SH)
              mem_wdata_reg <= {bus.mem_rdata[31:16], wdata_lo_reg};
            else if (op_reg == OP_SB)
              mem_wdata_reg <= {bus.mem_rdata[31:8], wdata_lo_reg[7:0]};
            else
              rdata_reg <= load_ext(op_reg, bus.mem_rdata);
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: the driver queues expected completions and writes,
// a negedge monitor pops and compares them as the sequencer reports done / mem_wr.
module tb_mem_access_seq;
  localparam int MEM_LAT = 2;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  mem_access_seq_if bus();

  mem_access_seq #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  done_exp_t done_q[$];
  wr_exp_t   wr_q[$];

  // Memoria model: one registered read stage, so data for an address set at edge n is sampled at edge n+2.
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe;
  assign bus.mem_rdata = rd_pipe;

  always @(posedge clk) begin
    rd_pipe <= mem[bus.mem_addr[7:2]];
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h0000_8001;
      mem[1]  <= 32'h0000_0007;
      mem[8]  <= 32'h1122_3344;
      mem[16] <= 32'h8000_00F3;
    end else if (bus.mem_wr && !reset) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Monitor: latency is counted from the first busy cycle (as 1) to the done cycle.
  int cyc = 0;
  int start_cyc = 0;
  logic prev_busy = 1'b0;
  int txn = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (bus.busy && !prev_busy) start_cyc = cyc;
        if (bus.mem_wr) begin
          if (wr_q.size() == 0) begin
            timeout("unexpected_write");
          end else begin
            wr_exp_t we;
            we = wr_q.pop_front();
            check("wr_addr", bus.mem_addr, we.addr);
            check("wr_data", bus.mem_wdata, we.data);
            $display("write addr=0x%08h data=0x%08h", bus.mem_addr, bus.mem_wdata);
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) begin
            timeout("unexpected_done");
          end else begin
            done_exp_t de;
            de = done_q.pop_front();
            txn++;
            check("done_latency", 32'(cyc - start_cyc + 1), 32'(de.lat));
            check("done_rdata", bus.rdata, de.rdata);
            check("done_busy", {31'b0, bus.busy}, 32'd1);
            $display("txn %0d: done rdata=0x%08h latency=%0d", txn, bus.rdata, cyc - start_cyc + 1);
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input bit exp_done, input logic [31:0] exp_rd, input int lat,
                       input bit has_wr, input logic [31:0] wr_data);
    int n = 0;
    done_exp_t de;
    wr_exp_t we;
    while (bus.busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n == 30) timeout("issue_wait_idle");
    if (exp_done) begin
      de.rdata = exp_rd;
      de.lat   = lat;
      done_q.push_back(de);
    end
    if (has_wr) begin
      we.addr = a;
      we.data = wr_data;
      wr_q.push_back(we);
    end
    bus.req = 1'b1;
    bus.op = o;
    bus.addr = a;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.op = ~o;
    bus.addr = ~a;
    bus.wdata = ~wd;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) timeout("wait_done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.req = 1'b0;
    bus.op = OP_LW;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    preload = 1'b0;
    @(negedge clk);

    // Sub-word and word loads of 0x8000_00F3
    issue(OP_LB,  32'h40, 32'h0, 1, 32'hFFFF_FFF3, 3, 0, 32'h0); wait_done();
    issue(OP_LBU, 32'h40, 32'h0, 1, 32'h0000_00F3, 3, 0, 32'h0); wait_done();
    issue(OP_LH,  32'h40, 32'h0, 1, 32'h0000_00F3, 3, 0, 32'h0); wait_done();
    issue(OP_LHU, 32'h40, 32'h0, 1, 32'h0000_00F3, 3, 0, 32'h0); wait_done();
    issue(OP_LW,  32'h40, 32'h0, 1, 32'h8000_00F3, 3, 0, 32'h0); wait_done();

    // Word store, then read back
    issue(OP_SW, 32'h10, 32'hDEAD_BEEF, 1, 32'h8000_00F3, 2, 1, 32'hDEAD_BEEF); wait_done();
    issue(OP_LW, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 3, 0, 32'h0); wait_done();

    // Read-modify-write byte and halfword stores
    issue(OP_SB, 32'h20, 32'hFFFF_FFAA, 1, 32'hDEAD_BEEF, 4, 1, 32'h1122_33AA); wait_done();
    issue(OP_LW, 32'h20, 32'h0, 1, 32'h1122_33AA, 3, 0, 32'h0); wait_done();
    issue(OP_SH, 32'h20, 32'h0000_5566, 1, 32'h1122_33AA, 4, 1, 32'h1122_5566); wait_done();
    issue(OP_LW, 32'h20, 32'h0, 1, 32'h1122_5566, 3, 0, 32'h0); wait_done();

    // req held high with inputs churning while an LW is in flight
    @(negedge clk);
    done_q.push_back('{rdata: 32'hDEAD_BEEF, lat: 3});
    bus.req = 1'b1;
    bus.op = OP_LW;
    bus.addr = 32'h10;
    bus.wdata = 32'h0;
    @(posedge clk);
    #1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      bus.op = 3'($urandom_range(0, 7));
      bus.addr = 32'($urandom_range(0, 63)) << 2;
      bus.wdata = $urandom;
    end
    if (!bus.done) timeout("t4_first_done");
    done_q.push_back('{rdata: 32'h8000_00F3, lat: 3});
    bus.op = OP_LW;
    bus.addr = 32'h40;
    @(negedge clk);
    check("t4_idle_gap", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check("t4_accept_after_done", {31'b0, bus.busy}, 32'd1);
    bus.req = 1'b0;
    wait_done();

    // Back-to-back LH then LW; rdata must hold until the second done
    issue(OP_LH, 32'h00, 32'h0, 1, 32'hFFFF_8001, 3, 0, 32'h0); wait_done();
    issue(OP_LW, 32'h04, 32'h0, 1, 32'h0000_0007, 3, 0, 32'h0);
    for (int k = 0; k < 30; k++) begin
      if (bus.done) break;
      check("t6_rdata_hold", bus.rdata, 32'hFFFF_8001);
      @(negedge clk);
    end
    if (!bus.done) timeout("t6_second_done");

    // Reset during the WR cycle of an SB: write suppressed, no done
    issue(OP_SB, 32'h20, 32'h0000_00BB, 0, 32'h0, 0, 1, 32'h1122_55BB);
    n = 0;
    while (!bus.mem_wr && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_wr) timeout("t5_wait_wr");
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_done", {31'b0, bus.done}, 32'd0);
    check("t5_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("t5_mem_word", mem[8], 32'h1122_5566);
    issue(OP_LW, 32'h20, 32'h0, 1, 32'h1122_5566, 3, 0, 32'h0); wait_done();

    repeat (5) @(negedge clk);
    check("pending_done", 32'(done_q.size()), 32'd0);
    check("pending_write", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
